// File: rtl/sync_fifo1_reader.sv
// Dequeue-side reader for the single-element CDC FIFO: pulls one wide word and
// streams it out as RATIO narrow beats (LSB chunk first), counting finished words.
module sync_fifo1_reader #(
    parameter int inWidth  = 128,
    parameter int outWidth = 32,
    parameter int cntWidth = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                fEMPTY_N,
    input  logic [inWidth-1:0]  fD_OUT,
    output logic                fDEQ,
    output logic                oVALID,
    output logic [outWidth-1:0] oDATA,
    output logic                oLAST,
    input  logic                oREADY,
    output logic [cntWidth-1:0] oWORDS
);
    localparam int RATIO = inWidth / outWidth;
    localparam int IDXW  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(RATIO - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [inWidth-1:0] data_buf;
    logic [IDXW-1:0]    idx;
    logic               accept;
    logic               last_accept;

    always_comb begin
        oVALID      = (state == SEND);
        oLAST       = oVALID && (idx == IDX_LAST);
        accept      = oVALID && oREADY;
        last_accept = accept && oLAST;
        // Reload on the last-beat accept so consecutive words stream without a bubble.
        fDEQ        = !RST && fEMPTY_N && ((state == EMPTY) || last_accept);
        state_nxt   = state;
        if (fDEQ)
            state_nxt = SEND;
        else if (last_accept)
            state_nxt = EMPTY;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= EMPTY;
            data_buf <= '0;
            idx      <= '0;
            oWORDS   <= '0;
        end else begin
            state <= state_nxt;
            if (last_accept)
                oWORDS <= oWORDS + cntWidth'(1);
            if (fDEQ) begin
                data_buf <= fD_OUT;
                idx      <= '0;
            end else if (accept) begin
                idx <= oLAST ? '0 : idx + IDXW'(1);
            end
        end
    end

    generate
        if (RATIO == 1) begin : g_ratio1
            assign oDATA = data_buf;
        end else begin : g_mux
            logic [RATIO-1:0][outWidth-1:0] chunks;
            assign chunks = data_buf;
            assign oDATA  = chunks[idx];
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo1_reader.sv
// Directed bench: FIFO source model feeds two readers (4:1 and 1:1 with a 2-bit
// counter); a beat scoreboard and word-count model check every cycle.
module tb_sync_fifo1_reader;
    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } beat_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic         a_en, a_deq, a_valid, a_last, a_rdy;
    logic [127:0] a_din;
    logic [31:0]  a_data;
    logic [15:0]  a_words;

    logic         b_en, b_deq, b_valid, b_last, b_rdy;
    logic [127:0] b_din, b_data;
    logic [1:0]   b_words;

    sync_fifo1_reader #(.inWidth(128), .outWidth(32), .cntWidth(16)) dut_a (
        .CLK(CLK), .RST(RST), .fEMPTY_N(a_en), .fD_OUT(a_din), .fDEQ(a_deq),
        .oVALID(a_valid), .oDATA(a_data), .oLAST(a_last), .oREADY(a_rdy), .oWORDS(a_words)
    );

    sync_fifo1_reader #(.inWidth(128), .outWidth(128), .cntWidth(2)) dut_b (
        .CLK(CLK), .RST(RST), .fEMPTY_N(b_en), .fD_OUT(b_din), .fDEQ(b_deq),
        .oVALID(b_valid), .oDATA(b_data), .oLAST(b_last), .oREADY(b_rdy), .oWORDS(b_words)
    );

    logic [127:0] src_a[$], src_b[$];
    beat_t        exp_a[$], exp_b[$];
    logic [15:0]  words_a = '0;
    logic [1:0]   words_b = '0;
    logic         deq_a_s, deq_b_s, rst_s;
    int           tests = 0;
    int           fails = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive_src();
        a_en  = (src_a.size() > 0);
        b_en  = (src_b.size() > 0);
        // Garbage on the data bus when empty: it must never be captured.
        a_din = a_en ? src_a[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
        b_din = b_en ? src_b[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic push_a(input logic [127:0] w);
        beat_t e;
        src_a.push_back(w);
        for (int k = 0; k < 4; k++) begin
            e.data = {96'd0, w[k*32 +: 32]};
            e.last = (k == 3);
            exp_a.push_back(e);
        end
        drive_src();
    endtask

    task automatic push_b(input logic [127:0] w);
        beat_t e;
        src_b.push_back(w);
        e.data = w;
        e.last = 1'b1;
        exp_b.push_back(e);
        drive_src();
    endtask

    // Negedge half: compare counters and any accepted beat against the scoreboard.
    task automatic sample();
        beat_t e;
        @(negedge CLK);
        rst_s   = RST;
        deq_a_s = a_deq;
        deq_b_s = b_deq;
        check("a_words", {112'd0, a_words}, {112'd0, words_a});
        check("b_words", {126'd0, b_words}, {126'd0, words_b});
        check("a_deq_when_empty", {127'd0, a_deq & ~a_en}, 128'd0);
        check("b_deq_when_empty", {127'd0, b_deq & ~b_en}, 128'd0);
        if (!RST && a_valid && a_rdy) begin
            if (exp_a.size() == 0) check("a_unexpected_beat", 128'd0, 128'd1);
            else begin
                e = exp_a.pop_front();
                check("a_data", {96'd0, a_data}, e.data);
                check("a_last", {127'd0, a_last}, {127'd0, e.last});
                if (e.last) words_a++;
            end
        end
        if (!RST && b_valid && b_rdy) begin
            if (exp_b.size() == 0) check("b_unexpected_beat", 128'd0, 128'd1);
            else begin
                e = exp_b.pop_front();
                check("b_data", b_data, e.data);
                check("b_last", {127'd0, b_last}, {127'd0, e.last});
                if (e.last) words_b++;
            end
        end
    endtask

    task automatic advance();
        @(posedge CLK);
        #1;
        if (rst_s) begin
            words_a = '0;
            words_b = '0;
        end
        if (deq_a_s && src_a.size() > 0) void'(src_a.pop_front());
        if (deq_b_s && src_b.size() > 0) void'(src_b.pop_front());
        drive_src();
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((exp_a.size() > 0 || exp_b.size() > 0) && n < limit) begin
            tick();
            n++;
        end
        check("drain_timeout", 128'(exp_a.size() + exp_b.size()), 128'd0);
    endtask

    initial begin
        beat_t e;
        a_rdy = 1'b1;
        b_rdy = 1'b1;
        drive_src();

        // Reset with a word already waiting in the FIFO
        push_a(128'h33333333_22222222_11111111_00000000);
        for (int i = 0; i < 3; i++) begin
            sample();
            check("rst_deq", {127'd0, a_deq}, 128'd0);
            check("rst_valid", {127'd0, a_valid}, 128'd0);
            check("rst_last", {127'd0, a_last}, 128'd0);
            check("rst_data", {96'd0, a_data}, 128'd0);
            check("rst_b_deq", {127'd0, b_deq}, 128'd0);
            advance();
        end
        RST = 1'b0;

        // Single word
        sample();
        check("sw_deq", {127'd0, a_deq}, 128'd1);
        check("sw_valid0", {127'd0, a_valid}, 128'd0);
        advance();
        for (int i = 0; i < 4; i++) begin
            sample();
            check("sw_valid", {127'd0, a_valid}, 128'd1);
            check("sw_last_pos", {127'd0, a_last}, {127'd0, (i == 3)});
            advance();
        end
        sample();
        check("sw_idle", {127'd0, a_valid}, 128'd0);
        check("sw_words", {112'd0, a_words}, 128'd1);
        advance();

        // Back-to-back words: reload on last-beat accept, no bubble
        push_a(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        push_a(128'h87654321_0FEDCBA9_13579BDF_2468ACE0);
        sample();
        check("b2b_deq0", {127'd0, a_deq}, 128'd1);
        advance();
        for (int i = 0; i < 8; i++) begin
            sample();
            check("b2b_valid", {127'd0, a_valid}, 128'd1);
            check("b2b_deq", {127'd0, a_deq}, {127'd0, (i == 3)});
            advance();
        end
        sample();
        check("b2b_idle", {127'd0, a_valid}, 128'd0);
        check("b2b_words", {112'd0, a_words}, 128'd3);
        advance();

        // Backpressure at beat 2 with the next word already waiting
        push_a(128'h33333333_22222222_11111111_00000000);
        push_a(128'h44444444_55555555_66666666_77777777);
        sample();
        check("bp_deq0", {127'd0, a_deq}, 128'd1);
        advance();
        tick();
        tick();
        a_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("bp_valid", {127'd0, a_valid}, 128'd1);
            check("bp_data", {96'd0, a_data}, 128'h22222222);
            check("bp_last", {127'd0, a_last}, 128'd0);
            check("bp_deq", {127'd0, a_deq}, 128'd0);
            advance();
        end
        a_rdy = 1'b1;
        drain(40);
        sample();
        check("bp_words", {112'd0, a_words}, 128'd5);
        advance();

        // Reset mid-word: partial word dropped, next FIFO word kept
        push_a(128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000);
        push_a(128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D);
        sample();
        check("rmw_deq0", {127'd0, a_deq}, 128'd1);
        advance();
        tick();
        tick();
        RST = 1'b1;
        sample();
        check("rmw_no_deq", {127'd0, a_deq}, 128'd0);
        advance();
        RST = 1'b0;
        do e = exp_a.pop_front(); while (!e.last && exp_a.size() > 0);
        sample();
        check("rmw_words", {112'd0, a_words}, 128'd0);
        check("rmw_valid", {127'd0, a_valid}, 128'd0);
        check("rmw_deq", {127'd0, a_deq}, 128'd1);
        advance();
        drain(40);

        // 1:1 ratio with 2-bit word counter: one word per cycle, wrap
        for (int i = 0; i < 5; i++)
            push_b({4{8'h10 + 8'(i), 24'h5A5A5A}});
        sample();
        check("r1_deq0", {127'd0, b_deq}, 128'd1);
        advance();
        for (int i = 0; i < 5; i++) begin
            sample();
            check("r1_valid", {127'd0, b_valid}, 128'd1);
            check("r1_last", {127'd0, b_last}, 128'd1);
            check("r1_deq", {127'd0, b_deq}, {127'd0, (i < 4)});
            advance();
        end
        sample();
        check("r1_wrap", {126'd0, b_words}, 128'd1);
        check("r1_idle", {127'd0, b_valid}, 128'd0);
        advance();
        drain(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
